mcamcs_evfifo: RTL

- Event buffer placed directly downstream of the MCA peak/timing capture stage.
- On each one-clock write flag from that stage, it captures the signed 14-bit peak and the 18-bit timing value as one 32-bit event word and stores it in a FIFO.
- The FIFO is first-word-fall-through and is drained by the CPU-side readout through a valid/ready handshake.
- The block counts events lost to overflow.

---
 rtl/mcamcs_evfifo_if.sv | 19 +
 rtl/mcamcs_evfifo.sv | 66 ++++++
 2 files changed

// File: rtl/mcamcs_evfifo_if.sv
// Event FIFO bus: peak-stage write side, CPU readout side and status.
interface mcamcs_evfifo_if #(parameter int AW = 9);
  logic          Wflg;
  logic [13:0]   pin;
  logic [17:0]   tin;
  logic [31:0]   dout;
  logic          dvalid;
  logic          dready;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic [15:0]   drop_cnt;
  logic          clr_drop;

  modport slave  (input  Wflg, pin, tin, dready, clr_drop,
                  output dout, dvalid, level, full, empty, drop_cnt);
  modport master (output Wflg, pin, tin, dready, clr_drop,
                  input  dout, dvalid, level, full, empty, drop_cnt);
endinterface

// File: rtl/mcamcs_evfifo.sv
// MCA event buffer: packs {peak, timing} into a 32-bit word and stores it in a
// first-word-fall-through FIFO drained by valid/ready. Counts overflow drops.
module mcamcs_evfifo #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  mcamcs_evfifo_if.slave bus
);
  localparam int          DEPTH   = 2**AW;
  localparam logic [AW:0] W_DEPTH = (AW+1)'(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_level;
  logic          r_full, r_empty;
  logic [15:0]   r_drop;

  logic          w_pop, w_push, w_drop;
  logic [AW:0]   w_level_nxt;

  // A pop frees a slot in the same cycle, so a push against a full FIFO is
  // accepted when it coincides with a pop.
  always_comb begin
    w_pop       = ~r_empty & bus.dready;
    w_push      = bus.Wflg & (~r_full | w_pop);
    w_drop      = bus.Wflg & r_full & ~w_pop;
    w_level_nxt = r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
  end

  // Storage is not reset; the head word is only meaningful while dvalid=1.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {bus.pin, bus.tin};
  end

  // Pointers and registered status flags move together on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == W_DEPTH);
      r_empty <= (w_level_nxt == '0);
    end
  end

  // Saturating drop counter; a clear wins over a simultaneous drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            r_drop <= '0;
    else if (bus.clr_drop)               r_drop <= '0;
    else if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
  end

  assign bus.dout     = r_mem[r_rptr];
  assign bus.dvalid   = ~r_empty;
  assign bus.level    = r_level;
  assign bus.full     = r_full;
  assign bus.empty    = r_empty;
  assign bus.drop_cnt = r_drop;
endmodule
